// File: rtl/ladder_scalar_mult_if.sv
// Request/result and point-op engine signals of ladder_scalar_mult.
// The slave view belongs to the ladder; the master view belongs to the controller and the engine.
interface ladder_scalar_mult_if #(
  parameter int unsigned KEY_W = 256,
  parameter int unsigned INT_W = 64,
  parameter int unsigned LEN_W = 9
) ();
  logic             start;
  logic             ct_mode;
  logic [KEY_W-1:0] k;
  logic [LEN_W-1:0] k_len;
  logic [INT_W-1:0] px;
  logic [INT_W-1:0] py;
  logic             p_inf;
  logic             busy;
  logic             done;
  logic [INT_W-1:0] res_x;
  logic [INT_W-1:0] res_y;
  logic             res_inf;
  logic             op_go;
  logic             op_dbl;
  logic [INT_W-1:0] op_ax;
  logic [INT_W-1:0] op_ay;
  logic [INT_W-1:0] op_bx;
  logic [INT_W-1:0] op_by;
  logic             op_a_inf;
  logic             op_b_inf;
  logic             op_done;
  logic [INT_W-1:0] op_rx;
  logic [INT_W-1:0] op_ry;
  logic             op_r_inf;

  modport slave (
    input  start, ct_mode, k, k_len, px, py, p_inf,
    output busy, done, res_x, res_y, res_inf,
    output op_go, op_dbl, op_ax, op_ay, op_bx, op_by, op_a_inf, op_b_inf,
    input  op_done, op_rx, op_ry, op_r_inf
  );

  modport master (
    output start, ct_mode, k, k_len, px, py, p_inf,
    input  busy, done, res_x, res_y, res_inf,
    input  op_go, op_dbl, op_ax, op_ay, op_bx, op_by, op_a_inf, op_b_inf,
    output op_done, op_rx, op_ry, op_r_inf
  );
endinterface

// File: rtl/ladder_scalar_mult.sv
// Montgomery-ladder scalar multiplier R = k*P driving a shared external add/double engine.
// Constant-time mode walks k_len bits unconditionally; variable mode starts at the top set bit.
module ladder_scalar_mult #(
  parameter int unsigned KEY_W = 256,
  parameter int unsigned INT_W = 64,
  parameter int unsigned LEN_W = 9
) (
  input  logic                clk,
  input  logic                rst,
  ladder_scalar_mult_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_INIT, S_SCAN, S_ADD, S_DBL, S_COMMIT, S_FIN
  } state_e;

  typedef struct packed {
    logic             inf;
    logic [INT_W-1:0] x;
    logic [INT_W-1:0] y;
  } pt_t;

  function automatic pt_t inf_pt();
    pt_t r;
    r     = '0;
    r.inf = 1'b1;
    return r;
  endfunction

  state_e           state_q, state_d;
  logic             ct_q, ct_d;
  logic [KEY_W-1:0] k_q, k_d;
  logic [LEN_W-1:0] klen_q, klen_d;
  logic [LEN_W-1:0] i_q, i_d;
  logic             b_q, b_d;
  pt_t              p_q, p_d;
  pt_t              r0_q, r0_d;
  pt_t              r1_q, r1_d;
  pt_t              t_q, t_d;
  pt_t              dr_q, dr_d;
  pt_t              res_q, res_d;
  pt_t              opa_q, opa_d;
  pt_t              opb_q, opb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             go_q, go_d;
  logic             dbl_q, dbl_d;
  logic [LEN_W-1:0] msb;
  pt_t              eng_res;

  assign eng_res = {bus.op_r_inf, bus.op_rx, bus.op_ry};

  always_comb begin
    msb = '0;
    for (int unsigned j = 0; j < KEY_W; j++) begin
      if (k_q[j]) msb = LEN_W'(j);
    end
  end

  // Engine states raise op_go only from a low op_go, so each request is preceded by a low cycle
  // and operands are loaded on the same edge that raises op_go.
  always_comb begin
    state_d = state_q;
    ct_d    = ct_q;
    k_d     = k_q;
    klen_d  = klen_q;
    i_d     = i_q;
    b_d     = b_q;
    p_d     = p_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    t_d     = t_q;
    dr_d    = dr_q;
    res_d   = res_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    go_d    = go_q;
    dbl_d   = dbl_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ct_d    = bus.ct_mode;
          k_d     = bus.k;
          klen_d  = bus.k_len;
          p_d     = {bus.p_inf, bus.px, bus.py};
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ct_q) begin
          r0_d    = inf_pt();
          r1_d    = p_q;
          i_d     = klen_q - LEN_W'(1);
          state_d = (klen_q == '0) ? S_FIN : S_SCAN;
        end else if (k_q == '0 || p_q.inf) begin
          r0_d    = inf_pt();
          state_d = S_FIN;
        end else begin
          r0_d    = p_q;
          r1_d    = inf_pt();
          i_d     = msb;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        if (i_q == '0) begin
          state_d = S_FIN;
        end else if (!go_q) begin
          go_d  = 1'b1;
          dbl_d = 1'b1;
          opa_d = r0_q;
          opb_d = r0_q;
        end else if (bus.op_done) begin
          go_d    = 1'b0;
          r1_d    = eng_res;
          i_d     = i_q - LEN_W'(1);
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        b_d     = |(k_q & (KEY_W'(1) << i_q));
        state_d = S_ADD;
      end
      S_ADD: begin
        if (!go_q) begin
          go_d  = 1'b1;
          dbl_d = 1'b0;
          opa_d = r0_q;
          opb_d = r1_q;
        end else if (bus.op_done) begin
          go_d    = 1'b0;
          t_d     = eng_res;
          state_d = S_DBL;
        end
      end
      S_DBL: begin
        if (!go_q) begin
          go_d  = 1'b1;
          dbl_d = 1'b1;
          opa_d = b_q ? r1_q : r0_q;
          opb_d = b_q ? r1_q : r0_q;
        end else if (bus.op_done) begin
          go_d    = 1'b0;
          dr_d    = eng_res;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (b_q) begin
          r0_d = t_q;
          r1_d = dr_q;
        end else begin
          r1_d = t_q;
          r0_d = dr_q;
        end
        i_d     = i_q - LEN_W'(1);
        state_d = (i_q == '0) ? S_FIN : S_SCAN;
      end
      S_FIN: begin
        res_d   = r0_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ct_q    <= 1'b0;
      k_q     <= '0;
      klen_q  <= '0;
      i_q     <= '0;
      b_q     <= 1'b0;
      p_q     <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      t_q     <= '0;
      dr_q    <= '0;
      res_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      go_q    <= 1'b0;
      dbl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ct_q    <= ct_d;
      k_q     <= k_d;
      klen_q  <= klen_d;
      i_q     <= i_d;
      b_q     <= b_d;
      p_q     <= p_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      t_q     <= t_d;
      dr_q    <= dr_d;
      res_q   <= res_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      go_q    <= go_d;
      dbl_q   <= dbl_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.res_x    = res_q.x;
  assign bus.res_y    = res_q.y;
  assign bus.res_inf  = res_q.inf;
  assign bus.op_go    = go_q;
  assign bus.op_dbl   = dbl_q;
  assign bus.op_ax    = opa_q.x;
  assign bus.op_ay    = opa_q.y;
  assign bus.op_a_inf = opa_q.inf;
  assign bus.op_bx    = opb_q.x;
  assign bus.op_by    = opb_q.y;
  assign bus.op_b_inf = opb_q.inf;

endmodule

// File: tb/tb_ladder_scalar_mult.sv
// Scoreboard bench for ladder_scalar_mult on y^2 = x^3+2x+2 mod 17 with a behavioural point-op engine.
module tb_ladder_scalar_mult;
  localparam int unsigned KW = 16;
  localparam int unsigned IW = 8;
  localparam int unsigned LW = 5;
  localparam int FP  = 17;
  localparam int ORD = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ladder_scalar_mult_if #(.KEY_W(KW), .INT_W(IW), .LEN_W(LW)) bus ();
  ladder_scalar_mult #(.KEY_W(KW), .INT_W(IW), .LEN_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { bit inf; int x; int y; } ept_t;
  typedef struct { string nm; bit inf; int x; int y; int ops; int lat; } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   ops_cnt = 0;
  int   last_lat = 0;
  bit   inflight = 1'b0;
  bit   busy_gap = 1'b0;
  bit   fixed_lat = 1'b1;
  int   fix_l = 3;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endfunction

  // ---------------- reference curve arithmetic ----------------
  function automatic int md(int v);
    return ((v % FP) + FP) % FP;
  endfunction

  function automatic int inv(int v);
    int vv = md(v);
    for (int i = 1; i < FP; i++) if (md(vv * i) == 1) return i;
    return 0;
  endfunction

  function automatic ept_t mkpt(bit inf, int x, int y);
    ept_t r;
    r.inf = inf; r.x = x; r.y = y;
    return r;
  endfunction

  function automatic ept_t padd(ept_t a, ept_t b);
    int l;
    ept_t r;
    if (a.inf) return b;
    if (b.inf) return a;
    if (a.x == b.x && md(a.y + b.y) == 0) return mkpt(1'b1, 0, 0);
    if (a.x == b.x) l = md((3 * a.x * a.x + 2) * inv(2 * a.y));
    else            l = md((b.y - a.y) * inv(b.x - a.x));
    r.inf = 1'b0;
    r.x   = md(l * l - a.x - b.x);
    r.y   = md(l * (a.x - r.x) - a.y);
    return r;
  endfunction

  function automatic ept_t smul(int n, ept_t p);
    ept_t r = mkpt(1'b1, 0, 0);
    for (int i = 0; i < n; i++) r = padd(r, p);
    return r;
  endfunction

  // ---------------- behavioural engine ----------------
  initial begin : engine
    int cnt;
    int cur_lat;
    ept_t a, b, r;
    cnt = 0; cur_lat = 1;
    bus.op_done = 1'b0; bus.op_rx = '0; bus.op_ry = '0; bus.op_r_inf = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst || bus.op_done) begin
        bus.op_done = 1'b0;
        cnt = 0;
      end else if (bus.op_go) begin
        if (cnt == 0) cur_lat = fixed_lat ? fix_l : int'($urandom_range(1, 20));
        cnt++;
        if (cnt >= cur_lat) begin
          a = mkpt(bus.op_a_inf, int'(bus.op_ax), int'(bus.op_ay));
          b = mkpt(bus.op_b_inf, int'(bus.op_bx), int'(bus.op_by));
          r = bus.op_dbl ? padd(a, a) : padd(a, b);
          bus.op_rx    = IW'(r.x);
          bus.op_ry    = IW'(r.y);
          bus.op_r_inf = r.inf;
          bus.op_done  = 1'b1;
          ops_cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- engine protocol checker ----------------
  initial begin : proto
    bit pg, pd;
    logic [4*IW+2:0] pop, cur;
    pg = 1'b0; pd = 1'b0; pop = '0;
    forever begin
      @(negedge clk); #1;
      cur = {bus.op_dbl, bus.op_a_inf, bus.op_b_inf, bus.op_ax, bus.op_ay, bus.op_bx, bus.op_by};
      if (!rst) begin
        pg = 1'b0; pd = 1'b0;
      end else begin
        if (pg && pd)           chk("op_go_low_gap", bus.op_go, 0);
        else if (pg && bus.op_go) chk("op_operands_stable", longint'(cur == pop), 1);
        pg = bus.op_go; pd = bus.op_done; pop = cur;
      end
    end
  end

  // ---------------- result monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        if (inflight && !bus.done && !bus.busy) busy_gap = 1'b1;
        if (bus.done) begin
          chk("done_expected", longint'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            last_lat = cyc - t0;
            chk({e.nm, "_inf"}, bus.res_inf, e.inf);
            if (!e.inf) begin
              chk({e.nm, "_x"}, bus.res_x, e.x);
              chk({e.nm, "_y"}, bus.res_y, e.y);
            end
            chk({e.nm, "_ops"}, ops_cnt, e.ops);
            if (e.lat >= 0) chk({e.nm, "_cycles"}, last_lat, e.lat);
            chk({e.nm, "_busy_held"}, busy_gap, 0);
            chk({e.nm, "_busy_drop"}, bus.busy, 0);
          end
          inflight = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(string nm, bit ct, int k, int klen, ept_t p, bit pinf);
    exp_t e;
    int keff, msb, pb;
    keff = ct ? (k & ((1 << klen) - 1)) : k;
    msb  = (k > 0) ? $clog2(k + 1) - 1 : 0;
    e.nm = nm;
    if (pinf) begin
      e.inf = 1'b1; e.x = 0; e.y = 0;
    end else begin
      ept_t r = smul(keff % ORD, p);
      e.inf = r.inf; e.x = r.x; e.y = r.y;
    end
    pb = 4 + 2 * fix_l;
    if (ct) begin
      e.ops = 2 * klen;
      e.lat = 2 + klen * pb;
    end else if (k == 0 || pinf) begin
      e.ops = 0;
      e.lat = 2;
    end else begin
      e.ops = (msb == 0) ? 0 : 1 + 2 * msb;
      e.lat = (msb == 0) ? 3 : 2 + (1 + fix_l) + msb * pb;
    end
    if (!fixed_lat) e.lat = -1;
    @(negedge clk);
    bus.ct_mode = ct; bus.k = KW'(k); bus.k_len = LW'(klen);
    bus.px = IW'(p.x); bus.py = IW'(p.y); bus.p_inf = pinf;
    bus.start = 1'b1;
    ops_cnt = 0;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    t0 = cyc;
    busy_gap = 1'b0;
    inflight = 1'b1;
  endtask

  task automatic wait_done(string nm);
    int n = 0;
    while (inflight && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done_in_budget"}, inflight, 0);
    if (inflight) begin
      rst = 1'b0;
      sb.delete();
      inflight = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run(string nm, bit ct, int k, int klen, ept_t p, bit pinf);
    send(nm, ct, k, klen, p, pinf);
    wait_done(nm);
  endtask

  initial begin : main
    ept_t g, p;
    int l1, kk, kl, n;
    bit found;
    g = mkpt(1'b0, 5, 1);
    bus.start = 1'b0; bus.ct_mode = 1'b0; bus.k = '0; bus.k_len = '0;
    bus.px = '0; bus.py = '0; bus.p_inf = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_op_go", bus.op_go, 0);
    chk("rst_res_inf", bus.res_inf, 0);
    chk("rst_res_x", bus.res_x, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run("var_k9", 1'b0, 9, 0, g, 1'b0);
    run("ct_k9", 1'b1, 9, 8, g, 1'b0);
    l1 = last_lat;
    run("ct_k80", 1'b1, 'h80, 8, g, 1'b0);
    chk("ct_equal_cycles", last_lat, l1);
    run("var_k19", 1'b0, 19, 0, g, 1'b0);
    run("ct_k19", 1'b1, 19, 5, g, 1'b0);
    run("var_k0", 1'b0, 0, 0, g, 1'b0);
    run("var_k1", 1'b0, 1, 0, g, 1'b0);
    run("var_k2", 1'b0, 2, 0, g, 1'b0);
    run("var_k3", 1'b0, 3, 0, g, 1'b0);
    run("ct_k3", 1'b1, 3, 6, g, 1'b0);
    run("var_pinf", 1'b0, 5, 0, g, 1'b1);
    run("ct_pinf", 1'b1, 5, 4, g, 1'b1);
    run("ct_high_bits", 1'b1, 'hFF09, 8, g, 1'b0);
    run("ct_klen0", 1'b1, 'h1234, 0, g, 1'b0);

    // start pulse while busy must be ignored
    send("var_k9_busy_start", 1'b0, 9, 0, g, 1'b0);
    repeat (5) @(negedge clk);
    bus.k = KW'(3); bus.ct_mode = 1'b1; bus.k_len = LW'(2); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("var_k9_busy_start");
    repeat (100) @(negedge clk);
    #1;
    chk("held_res_x", bus.res_x, 7);
    chk("held_res_y", bus.res_y, 6);
    chk("idle_busy", bus.busy, 0);

    // reset during a doubling abandons the computation
    send("ct_abandoned", 1'b1, 'hB5, 8, g, 1'b0);
    found = 1'b0;
    n = 0;
    while (!found && n < 500) begin
      @(negedge clk);
      n++;
      found = bus.op_go && bus.op_dbl;
    end
    chk("reached_dbl", found, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_op_go", bus.op_go, 0);
    chk("mid_rst_op_dbl", bus.op_dbl, 0);
    chk("mid_rst_res_x", bus.res_x, 0);
    chk("mid_rst_res_y", bus.res_y, 0);
    chk("mid_rst_op_ax", bus.op_ax, 0);
    chk("mid_rst_op_a_inf", bus.op_a_inf, 0);
    sb.delete();
    inflight = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    run("var_k10", 1'b0, 10, 0, g, 1'b0);

    // random transactions with random engine latency
    fixed_lat = 1'b0;
    for (int t = 0; t < 40; t++) begin
      p  = smul(int'($urandom_range(1, ORD - 1)), g);
      kk = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) kk = kk & 'h3F;
      kl = int'($urandom_range(0, KW));
      run($sformatf("rnd%0d", t), 1'(($urandom) & 1), kk, kl, p, ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ladder_scalar_mult.md
Name: ladder_scalar_mult

Overview:
- Parametrised Montgomery-ladder scalar multiplier (R = k·P) over a prime-field Weierstrass curve.
- Successor to the fixed ladder FSM in ecc/. Adds:
  - an effective scalar length input;
  - a constant-time mode that processes every bit and never skips leading zeros;
  - a start/busy/done handshake;
  - a shared external point-op engine port (add or double, with infinity flags), so one arithmetic unit serves the whole ladder.
- Sits between the ECC top-level controller and the get_PQ/get_2P point-op engine.

Parameters:
- KEY_W, 256, scalar register width in bits.
- INT_W, 64, field element width in bits.
- LEN_W, 9, width of k_len; must satisfy 2^LEN_W > KEY_W.

Ports:
- clk  in  1  clock, all flops on rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- ct_mode  in  1  1 = constant-time, 0 = variable-time; captured at start.
- k  in  KEY_W  scalar; captured at start.
- k_len  in  LEN_W  number of scalar bits processed in CT mode (bits k_len-1..0); captured at start.
- px, py  in  INT_W each  base point; captured at start.
- p_inf  in  1  base point is the point at infinity; captured at start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result valid on that cycle.
- res_x, res_y  out  INT_W each  result coordinates; held until next accepted start.
- res_inf  out  1  result is the point at infinity; held like res_x.
- op_go  out  1  engine request, level.
- op_dbl  out  1  1 = double A, 0 = A+B.
- op_ax, op_ay, op_bx, op_by  out  INT_W each  engine operands.
- op_a_inf, op_b_inf  out  1 each  operand infinity flags.
- op_done  in  1  engine completion.
- op_rx, op_ry  in  INT_W each  engine result.
- op_r_inf  in  1  engine result infinity flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state to IDLE;
  - busy, done, op_go, op_dbl, res_inf = 0;
  - res_x, res_y, all operand outputs and internal R0/R1/T registers = 0;
  - a reset mid-operation abandons the computation with no done pulse.
- States: IDLE, LOAD, INIT, SCAN, ADD, DBL, COMMIT, FIN.
- IDLE:
  - on start=1, capture inputs and go to LOAD; busy rises the next cycle;
  - start while busy is ignored.
- LOAD:
  - CT mode: R0 = infinity, R1 = P; i = k_len-1; go to SCAN. If k_len = 0, go to FIN.
  - Variable mode: msb = highest set bit of k (priority encoder). If k = 0 or p_inf = 1, go straight to FIN with result infinity and issue no engine ops. Otherwise R0 = P, R1 = infinity, i = msb, go to INIT.
- INIT (variable mode only): double R0 via the engine, R1 = 2P, i = msb-1. If msb = 0, go to FIN with R0 = P.
- SCAN:
  - b = k[i];
  - go to ADD.
- ADD:
  - op_dbl = 0, A = R0, B = R1;
  - result goes to T.
- DBL:
  - op_dbl = 1, A = (b ? R1 : R0), using the pre-step values.
- COMMIT:
  - if b = 0: R1 = T, R0 = double result; if b = 1: R0 = T, R1 = double result;
  - decrement i; if i was 0 go to FIN, else go to SCAN.
- FIN: res = R0 (with inf flag); pulse done; drop busy; go to IDLE.
- Engine handshake:
  - op_go is raised together with stable operands and held until the cycle op_done = 1 is sampled;
  - op_rx, op_ry, op_r_inf are captured on that cycle;
  - op_go is low for at least one cycle between requests;
  - operands never change while op_go = 1.
- Op count:
  - CT mode issues exactly 2·k_len engine ops, independent of the value of k, including leading zeros and infinity operands; the engine resolves infinity.
  - Variable mode issues 1 + 2·msb ops.
- Latency with a zero-wait engine (op_done on the first op_go cycle): the done cycle is deterministic per mode and k_len. The bench measures and locks it.
- k bits at index ≥ k_len are ignored in CT mode.

Test Plan:
- Shared setup for all cases: curve y² = x³+2x+2 mod 17, P = (5,1), behavioural engine with 3-cycle latency.
- Variable mode, k = 9 → res = (7,6), res_inf = 0; 7 ops issued; busy high throughout; single done pulse.
- CT mode, k = 9, k_len = 8 → res = (7,6); exactly 16 ops. Then k = 0x80, k_len = 8 → also exactly 16 ops and equal cycle count.
- Boundaries:
  - k = 19 → res_inf = 1 in both modes;
  - variable mode k = 0 → res_inf = 1, zero ops, done within 3 cycles of start;
  - variable mode k = 1 → res = (5,1), 0 ops;
  - k = 2 → (6,3);
  - k = 3 → (10,6).
- p_inf = 1, k = 5 → res_inf = 1 in both modes.
- Assert start during busy → ignored, result unchanged. Pull rst low mid-DBL → outputs zero immediately, no done; a following start with k = 10 gives (7,11).
- Engine protocol checker: op_go is never re-raised without a low gap, and operands stay stable while op_go = 1, across random engine latencies of 1–20 cycles.
